// File: rtl/solve_dispatch.sv
// solve_dispatch: buffers (x, a, b, c) operand tuples in a small FIFO and
// issues them one at a time to the quadratic solver using its
// enable/ready/valid handshake. It also reports dropped pushes and counts
// completed operations.
module solve_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [7:0]  in_x,
    input  logic signed [15:0] in_a,
    input  logic signed [15:0] in_b,
    input  logic signed [15:0] in_c,
    input  logic               in_push,
    output logic               in_full,
    output logic signed [7:0]  s_x,
    output logic signed [15:0] s_a,
    output logic signed [15:0] s_b,
    output logic signed [15:0] s_c,
    output logic               s_enable,
    input  logic               s_ready,
    input  logic               s_valid,
    output logic               busy,
    output logic [AW:0]        level,
    output logic               drop_err,
    output logic [15:0]        issued
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VALID, WAIT_READY} state_t;

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state, next_state;
    logic [55:0]   mem [DEPTH];
    logic [55:0]   head;
    logic [AW-1:0] wptr, rptr;
    logic          pop, push_ok, drop;

    // Pop only from IDLE. The level used here is the registered one, so an
    // entry pushed this cycle into an empty FIFO can be popped next cycle at
    // the earliest. A push into a full FIFO is accepted only when a pop
    // frees a slot on the same edge.
    assign pop     = (state == IDLE) && (level != '0) && s_ready;
    assign push_ok = in_push && ((level != FULL_LVL) || pop);
    assign drop    = in_push && !push_ok;
    assign head    = mem[rptr];
    assign in_full = (level == FULL_LVL);
    assign busy    = (state != IDLE);

    // Storage array: data only, so it has no reset. A reset discards its
    // contents by clearing the pointers and the level.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr] <= {in_x, in_a, in_b, in_c};
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (drop) drop_err <= 1'b1;
        end
    end

    // State register, registered enable pulse and completion counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            s_enable <= 1'b0;
            issued   <= '0;
        end else begin
            state    <= next_state;
            s_enable <= (next_state == ISSUE);
            if ((state == WAIT_VALID) && s_valid) issued <= issued + 16'd1;
        end
    end

    // Operand registers: loaded only on a pop, then held for the whole operation
    always_ff @(posedge clock) begin
        if (reset) begin
            s_x <= '0;
            s_a <= '0;
            s_b <= '0;
            s_c <= '0;
        end else if (pop) begin
            s_x <= head[55:48];
            s_a <= head[47:32];
            s_b <= head[31:16];
            s_c <= head[15:0];
        end
    end

    // Next-state decode of the issue handshake
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (pop)     next_state = ISSUE;
            ISSUE:                   next_state = WAIT_VALID;
            WAIT_VALID: if (s_valid) next_state = WAIT_READY;
            WAIT_READY: if (s_ready) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_solve_dispatch.sv
// Testbench for solve_dispatch. A behavioural solver model answers each
// enable pulse. A scoreboard queue holds the expected operand tuples in
// FIFO order and is compared at every enable pulse.
module tb_solve_dispatch;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic signed [7:0]  in_x = '0;
    logic signed [15:0] in_a = '0, in_b = '0, in_c = '0;
    logic               in_push = 1'b0;
    logic               in_full;
    logic signed [7:0]  s_x;
    logic signed [15:0] s_a, s_b, s_c;
    logic               s_enable, s_ready, s_valid, busy, drop_err;
    logic [AW:0]        level;
    logic [15:0]        issued;

    // The solver handshake comes either from the model or from direct drive.
    logic use_model = 1'b0, t_ready = 1'b0, t_valid = 1'b0;
    logic m_ready = 1'b1, m_valid = 1'b0;
    assign s_ready = use_model ? m_ready : t_ready;
    assign s_valid = use_model ? m_valid : t_valid;

    // Solver model timing: cycles to valid, valid width, cycles to ready
    int lat = 3, vhold = 1, rdelay = 1;

    int          n_pass = 0, n_total = 0, en_count = 0;
    logic [55:0] sb[$];
    logic [55:0] cur = '0;
    logic        inflight = 1'b0, prev_en = 1'b0;

    solve_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_push(in_push), .in_full(in_full),
        .s_x(s_x), .s_a(s_a), .s_b(s_b), .s_c(s_c),
        .s_enable(s_enable), .s_ready(s_ready), .s_valid(s_valid),
        .busy(busy), .level(level), .drop_err(drop_err), .issued(issued)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Solver model: the model drives at the falling edge. It drops ready on
    // an enable, raises valid after lat cycles, then restores ready.
    initial begin
        forever begin
            @(negedge clock);
            if (s_enable && use_model) begin
                m_ready = 1'b0;
                if (lat > 0) repeat (lat) @(negedge clock);
                m_valid = 1'b1;
                repeat (vhold) @(negedge clock);
                m_valid = 1'b0;
                if (rdelay > 0) repeat (rdelay) @(negedge clock);
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: the monitor samples 1 time unit after the falling edge. It
    // checks enable width, FIFO order and that the operands are held until valid.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                sb.delete();
                inflight = 1'b0;
            end else if (s_enable) begin
                en_count++;
                check("enable_single", 64'(prev_en), 64'd0);
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check("operands", 64'({s_x, s_a, s_b, s_c}), 64'(cur));
                    inflight = 1'b1;
                end
            end else if (inflight && s_valid && use_model) begin
                check("hold_at_valid", 64'({s_x, s_a, s_b, s_c}), 64'(cur));
                inflight = 1'b0;
            end
            prev_en = s_enable;
        end
    end

    // The main sequence acts 3 time units after each falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #3;
        end
    endtask

    task automatic push(input logic signed [7:0] x, input logic signed [15:0] a,
                        input logic signed [15:0] b, input logic signed [15:0] c,
                        input bit accept);
        in_x = x; in_a = a; in_b = b; in_c = c;
        in_push = 1'b1;
        if (accept) sb.push_back({x, a, b, c});
        step(1);
        in_push = 1'b0;
    endtask

    task automatic wait_en(input int target, input int budget);
        int k = 0;
        while (en_count < target && k < budget) begin
            step(1);
            k++;
        end
        check("enable_count", 64'(en_count), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        check("return_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        int          base;
        logic [15:0] iss;

        // Reset, then idle with the solver ready and no pushes.
        use_model = 1'b1;
        step(2);
        reset = 1'b0;
        step(20);
        check("idle_no_enable", 64'(en_count), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        check("reset_issued", 64'(issued), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_drop", 64'(drop_err), 64'd0);
        check("reset_full", 64'(in_full), 64'd0);
        check("reset_operands", 64'({s_x, s_a, s_b, s_c}), 64'd0);

        // Single operation with a 3-cycle solver.
        lat = 3; vhold = 1; rdelay = 1;
        push(8'sd3, 16'sd2, -16'sd5, 16'sd7, 1'b1);
        wait_en(1, 20);
        wait_idle(50);
        check("single_issued", 64'(issued), 64'd1);
        check("single_enables", 64'(en_count), 64'd1);
        check("single_level", 64'(level), 64'd0);

        // Fill the FIFO with the solver stalled; the fifth push is dropped.
        use_model = 1'b0; t_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'(10 + i), 16'(100 * i), 16'(-i - 1), 16'(1000 + i), 1'b1);
        check("fill_full", 64'(in_full), 64'd1);
        check("fill_level", 64'(level), 64'd4);
        check("fill_no_drop", 64'(drop_err), 64'd0);
        push(8'sd99, 16'sd9, 16'sd9, 16'sd9, 1'b0);
        check("drop_flag", 64'(drop_err), 64'd1);
        check("drop_level", 64'(level), 64'd4);
        lat = 1; vhold = 1; rdelay = 0;
        use_model = 1'b1;
        wait_en(5, 60);
        wait_idle(40);
        check("drain_level", 64'(level), 64'd0);
        check("drain_full", 64'(in_full), 64'd0);
        check("drain_issued", 64'(issued), 64'd5);
        check("drop_sticky", 64'(drop_err), 64'd1);

        // A push into a full FIFO is accepted when a pop happens on the same edge.
        do_reset();
        check("reset_clears_drop", 64'(drop_err), 64'd0);
        base = en_count;
        use_model = 1'b0; t_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'(-20 - i), 16'(-1000 * i), 16'(i), 16'(7 * i), 1'b1);
        use_model = 1'b1;
        push(8'sd55, -16'sd1, -16'sd2, -16'sd3, 1'b1);
        check("pushpop_level", 64'(level), 64'd4);
        check("pushpop_no_drop", 64'(drop_err), 64'd0);
        check("pushpop_full", 64'(in_full), 64'd1);
        wait_en(base + 5, 100);
        wait_idle(40);
        check("pushpop_issued", 64'(issued), 64'd5);
        check("pushpop_drained", 64'(level), 64'd0);

        // Valid in the same cycle as enable: the operation completes on the
        // first WAIT_VALID cycle.
        lat = 0; vhold = 2; rdelay = 0;
        base = en_count;
        iss = issued;
        push(-8'sd7, 16'sd300, -16'sd300, 16'sd1, 1'b1);
        wait_en(base + 1, 20);
        check("fast_issue_cycle", 64'(issued), 64'(iss));
        step(1);
        check("fast_wait_valid", 64'(issued), 64'(iss));
        step(1);
        check("fast_incremented", 64'(issued), 64'(iss + 16'd1));
        check("fast_wait_ready", 64'(busy), 64'd1);
        step(1);
        check("fast_idle", 64'(busy), 64'd0);
        check("fast_once", 64'(issued), 64'(iss + 16'd1));

        // Reset during WAIT_VALID with two entries queued.
        lat = 10; vhold = 1; rdelay = 1;
        base = en_count;
        push(8'sd1, 16'sd1, 16'sd1, 16'sd1, 1'b1);
        push(8'sd2, 16'sd2, 16'sd2, 16'sd2, 1'b1);
        push(8'sd3, 16'sd3, 16'sd3, 16'sd3, 1'b1);
        step(1);
        check("midop_busy", 64'(busy), 64'd1);
        check("midop_level", 64'(level), 64'd2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_level", 64'(level), 64'd0);
        check("abort_enable", 64'(s_enable), 64'd0);
        check("abort_issued", 64'(issued), 64'd0);
        check("abort_operands", 64'({s_x, s_a, s_b, s_c}), 64'd0);
        step(20);
        check("abort_no_enable", 64'(en_count), 64'(base + 1));
        check("spurious_valid", 64'(issued), 64'd0);
        lat = 2;
        push(8'sd127, 16'sd32767, -16'sd32768, 16'sd0, 1'b1);
        wait_en(base + 2, 20);
        wait_idle(40);
        check("recover_issued", 64'(issued), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
